// File: rtl/aes_ctr_keystream_xor.sv
// Consumer side of the AES-256 CTR generator: buffers 512-bit keystream batches
// and XORs them word-by-word (MSB word first) into a 32-bit data stream.
module aes_ctr_keystream_xor #(
    parameter int BATCH_BITS        = 512,
    parameter int WORD_BITS         = 32,
    parameter int XOF_TARGET_BLOCKS = 44,
    parameter int PRF_TARGET_BLOCKS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [BATCH_BITS-1:0] ks_batch_i,
    input  logic                  ks_valid_i,
    output logic                  ks_ready_o,
    input  logic [WORD_BITS-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [WORD_BITS-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [5:0]            blocks_done,
    output logic                  done
);

    localparam int WORDS           = BATCH_BITS / WORD_BITS;
    localparam int PTR_BITS        = $clog2(WORDS);
    localparam int SEL_BITS        = $clog2(WORD_BITS);
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCKS_PER_BATCH = 4;

    localparam logic [7:0] XOF_LAST    = 8'(XOF_TARGET_BLOCKS * WORDS_PER_BLOCK - 1);
    localparam logic [7:0] PRF_LAST    = 8'(PRF_TARGET_BLOCKS * WORDS_PER_BLOCK - 1);
    localparam logic [3:0] XOF_BATCHES = 4'(XOF_TARGET_BLOCKS / BLOCKS_PER_BATCH);
    localparam logic [3:0] PRF_BATCHES = 4'(PRF_TARGET_BLOCKS / BLOCKS_PER_BATCH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic                   mode_q;
    logic [BATCH_BITS-1:0]  fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             entries;
    logic [PTR_BITS-1:0]    word_ptr;
    logic [7:0]             word_cnt;
    logic [3:0]             batches_loaded;

    logic                   ks_push;
    logic                   din_hs;
    logic                   pop;
    logic [7:0]             last_word;
    logic [3:0]             target_batches;
    logic [BATCH_BITS-1:0]  head_batch;
    logic [WORD_BITS-1:0]   ks_word;

    assign last_word      = mode_q ? PRF_LAST : XOF_LAST;
    assign target_batches = mode_q ? PRF_BATCHES : XOF_BATCHES;

    assign ks_ready_o = (state == S_RUN) && (entries < 2'd2) && (batches_loaded < target_batches);
    assign din_ready  = (state == S_RUN) && (entries != 2'd0) && (!dout_valid || dout_ready);
    assign done       = (state == S_DONE);

    assign ks_push = ks_valid_i && ks_ready_o;
    assign din_hs  = din_valid && din_ready;
    assign pop     = din_hs && (word_ptr == PTR_BITS'(WORDS - 1));

    // Inverting the pointer maps word 0 onto the top slice of the batch.
    assign head_batch = fifo_mem[rd_ptr];
    assign ks_word    = head_batch[{~word_ptr, SEL_BITS'(0)} +: WORD_BITS];

    // NOTE: batch storage carries no reset; 'entries' alone says which slots hold live data.
    always_ff @(posedge clk) begin
        if (ks_push) begin
            fifo_mem[wr_ptr] <= ks_batch_i;
        end
    end

    // NOTE: all state uses non-blocking assignments; where the start branch below
    // re-assigns a register, that later assignment is the one that takes effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mode_q         <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            entries        <= 2'd0;
            word_ptr       <= '0;
            word_cnt       <= 8'd0;
            batches_loaded <= 4'd0;
            blocks_done    <= 6'd0;
            dout           <= '0;
            dout_valid     <= 1'b0;
        end else begin
            if (ks_push) begin
                wr_ptr         <= ~wr_ptr;
                batches_loaded <= batches_loaded + 4'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({ks_push, pop})
                2'b10:   entries <= entries + 2'd1;
                2'b01:   entries <= entries - 2'd1;
                default: entries <= entries;
            endcase

            if (din_hs) begin
                dout       <= din ^ ks_word;
                dout_valid <= 1'b1;
                word_ptr   <= word_ptr + PTR_BITS'(1);
                word_cnt   <= word_cnt + 8'd1;
                if (word_ptr[1:0] == 2'd3) begin
                    blocks_done <= blocks_done + 6'd1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        mode_q         <= mode;
                        wr_ptr         <= 1'b0;
                        rd_ptr         <= 1'b0;
                        entries        <= 2'd0;
                        word_ptr       <= '0;
                        word_cnt       <= 8'd0;
                        batches_loaded <= 4'd0;
                        blocks_done    <= 6'd0;
                    end
                end
                S_RUN: begin
                    if (din_hs && (word_cnt == last_word)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!dout_valid || dout_ready) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_ctr_keystream_xor.md
Name: aes_ctr_keystream_xor

Overview:
- Consumer end of the AES-256 CTR keystream generator: accepts 512-bit keystream batches (4 AES blocks), buffers them and XORs them word-by-word with a 32-bit data stream, producing ciphertext or plaintext (CTR encryption and decryption are the same operation).
- Sits between the 4-core CTR generator's batch output and the downstream data path.
- Counts consumed blocks against the per-mode target (XOF/PRF) and flags completion.

Parameters:
- BATCH_BITS, 512, keystream batch width (4 x 128-bit blocks)
- WORD_BITS, 32, data word width; 16 words per batch
- XOF_TARGET_BLOCKS, 44, blocks consumed in mode 0 (11 batches, 176 words)
- PRF_TARGET_BLOCKS, 8, blocks consumed in mode 1 (2 batches, 32 words)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a job, sampled in IDLE or DONE only
- mode  in  1  0 = XOF, 1 = PRF; latched on accepted start
- ks_batch_i  in  512  keystream batch; bits [511:384] are block 0, [127:0] are block 3
- ks_valid_i  in  1  batch valid
- ks_ready_o  out  1  batch accepted when ks_valid_i & ks_ready_o
- din  in  32  input data word
- din_valid  in  1  data valid
- din_ready  out  1  data accepted when din_valid & din_ready
- dout  out  32  din XOR keystream word, registered
- dout_valid  out  1  dout valid
- dout_ready  in  1  downstream ready
- blocks_done  out  6  count of fully consumed 128-bit blocks in the current job
- done  out  1  high in DONE state

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; buffer empty; all counters 0; ks_ready_o=0, din_ready=0, dout_valid=0, dout=0, blocks_done=0, done=0. Reset mid-job discards buffered batches and any pending dout.
- FSM states:
  - IDLE: start -> RUN; latch mode, clear counters.
  - RUN: after the last word of the target is accepted -> DRAIN.
  - DRAIN: when dout handshakes (or dout_valid is already 0) -> DONE.
  - DONE: start -> RUN (new job, counters cleared). Otherwise DONE holds.
- start in RUN or DRAIN is ignored.
- Keystream buffer:
  - Two-entry FIFO of 512-bit batches.
  - Word pointer 0..15 into the head entry. Word k = head[511-32k -: 32], so the MSB word is consumed first.
- ks_ready_o = (state==RUN) & (entries<2) & (batches_loaded < target/4), where target is the latched mode's block count.
  - Batches beyond the target are never accepted.
- din_ready = (state==RUN) & (entries>0) & (!dout_valid | dout_ready).
- On a din handshake:
  - dout <= din ^ head word; dout_valid <= 1. Latency is 1 cycle.
  - Word pointer increments. At pointer 15 it wraps to 0 and the head entry is popped.
  - Every 4th word increments blocks_done.
- dout_valid clears on (dout_valid & dout_ready) if no new din handshake occurs in the same cycle.
- Back-to-back full throughput: 1 word/clk while dout_ready=1 and keystream is available.
- A pop and a push in the same cycle keeps the entry count unchanged; both must take effect.
- A push while entries==1 and the head is mid-consumption must not disturb the word pointer.
- Stall: dout_valid=1 & dout_ready=0 holds dout stable and holds din_ready=0.
- Word count width ≥ 8 bits. Last word = target*4 - 1 (175 XOF, 31 PRF).
- done = (state==DONE). blocks_done holds its final value (44 or 8) in DONE until the next start.

Test Plan:
- PRF basic: reset, start with mode=1, supply 2 batches of all-0xA5 bytes, din = 0..31, dout_ready=1 -> dout[k] = k ^ 32'hA5A5A5A5 one cycle after each input, blocks_done=8, done rises after the last dout handshake, ks_ready_o stays 0 for a 3rd batch.
- Word order: batch = 16 distinct words W0..W15 (W0 in bits [511:480]), din=0 -> dout sequence is exactly W0, W1, …, W15.
- XOF full: mode=0, 11 batches fed as soon as ks_ready_o rises -> 176 outputs, blocks_done=44, done=1, and a 12th batch is refused.
- Backpressure: toggle dout_ready 1/0 every cycle and gap ks_valid_i -> no lost or duplicated words, dout stable while stalled, XOR results still match the model.
- Simultaneous push/pop: hold the buffer at 1 entry, present a new batch on the same cycle word 15 is consumed -> count stays 1, next dout uses word 0 of the new batch.
- Reset mid-job: assert rst_n=0 after 10 words in XOF -> all outputs return to reset values. A fresh start then behaves like the first job, with blocks_done restarting from 0.
